unireg_nbit: RTL



---
 rtl/unireg_pkg.sv | 17 +
 rtl/unireg_next.sv | 40 ++++
 rtl/unireg_nbit.sv | 73 +++++++
 3 files changed

// File: rtl/unireg_pkg.sv
// rtl/unireg_pkg.sv - mode encoding shared by the unireg_nbit register and its next-state logic
package unireg_pkg;

    localparam int UNIREG_MODE_W = 3;

    typedef enum logic [UNIREG_MODE_W-1:0] {
        MODE_HOLD  = 3'd0,
        MODE_LOAD  = 3'd1,
        MODE_SHL   = 3'd2,
        MODE_SHR   = 3'd3,
        MODE_ROTL  = 3'd4,
        MODE_ROTR  = 3'd5,
        MODE_CNTUP = 3'd6,
        MODE_CNTDN = 3'd7
    } unireg_mode_t;

endpackage

// File: rtl/unireg_next.sv
// rtl/unireg_next.sv - combinational next-state and counter-wrap logic for unireg_nbit
module unireg_next
    import unireg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]   q,
    input  unireg_mode_t       mode,
    input  logic [WIDTH-1:0]   d,
    input  logic               si_lsb,
    input  logic               si_msb,
    output logic [WIDTH-1:0]   q_next,
    output logic               wrap
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    always_comb begin
        q_next = q;
        wrap   = 1'b0;
        case (mode)
            MODE_HOLD:  q_next = q;
            MODE_LOAD:  q_next = d;
            MODE_SHL:   q_next = {q[WIDTH-2:0], si_lsb};
            MODE_SHR:   q_next = {si_msb, q[WIDTH-1:1]};
            MODE_ROTL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ROTR:  q_next = {q[0], q[WIDTH-1:1]};
            // wrap marks the edge where the count leaves its end of range
            MODE_CNTUP: begin
                q_next = q + ONE;
                wrap   = &q;
            end
            MODE_CNTDN: begin
                q_next = q - ONE;
                wrap   = ~|q;
            end
        endcase
    end

endmodule

// File: rtl/unireg_nbit.sv
// rtl/unireg_nbit.sv - falling-edge universal register with clear/preset/enable; UNIREG_NBIT_PARITY_EN adds q_par
module unireg_nbit
    import unireg_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}}
) (
    input  logic                     clk,
    input  logic                     Cl,
    input  logic                     Pr,
    input  logic                     en,
    input  logic [UNIREG_MODE_W-1:0] mode,
    input  logic [WIDTH-1:0]         d,
    input  logic                     si_lsb,
    input  logic                     si_msb,
    output logic [WIDTH-1:0]         q,
    output logic                     so_msb,
    output logic                     so_lsb,
    output logic                     zero,
`ifdef UNIREG_NBIT_PARITY_EN
    output logic                     q_par,
`endif
    output logic                     tc
);

    logic [WIDTH-1:0] q_next;
    logic             wrap;

    unireg_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .q      (q),
        .mode   (unireg_mode_t'(mode)),
        .d      (d),
        .si_lsb (si_lsb),
        .si_msb (si_msb),
        .q_next (q_next),
        .wrap   (wrap)
    );

    // Cl outranks Pr, which outranks en; tc is a single-edge pulse
    always_ff @(negedge clk) begin
        if (!Cl) begin
            q  <= '0;
            tc <= 1'b0;
        end else if (!Pr) begin
            q  <= PRESET_VAL;
            tc <= 1'b0;
        end else if (!en) begin
            tc <= 1'b0;
        end else begin
            q  <= q_next;
            tc <= wrap;
        end
    end

`ifdef UNIREG_NBIT_PARITY_EN
    always_ff @(negedge clk) begin
        if (!Cl) begin
            q_par <= 1'b0;
        end else if (!Pr) begin
            q_par <= ^PRESET_VAL;
        end else if (en) begin
            q_par <= ^q_next;
        end
    end
`endif

    assign so_msb = q[WIDTH-1];
    assign so_lsb = q[0];
    assign zero   = (q == '0);

endmodule
